// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the multi-channel UART command receiver.
// Wave codes, command bytes and the receive FSM state encoding.
package uart_cmd_pkg;

  localparam logic [2:0] WAVE_TRI = 3'b000;
  localparam logic [2:0] WAVE_SAW = 3'b001;
  localparam logic [2:0] WAVE_SQR = 3'b010;
  localparam logic [2:0] WAVE_SIN = 3'b011;

  localparam logic [7:0] CMD_T       = 8'h54;
  localparam logic [7:0] CMD_S       = 8'h53;
  localparam logic [7:0] CMD_Q       = 8'h51;
  localparam logic [7:0] CMD_W       = 8'h57;
  localparam logic [7:0] CMD_N       = 8'h4E;
  localparam logic [7:0] CMD_F       = 8'h46;
  localparam logic [7:0] CMD_CH_BASE = 8'h80;
  localparam logic [7:0] CMD_BCAST   = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// Oversampled 8N1 receiver: synchroniser, tick generator, 3-sample majority
// vote and framing FSM with false-start rejection and break recovery.
module uart_rx_core
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int DIV   = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] S_LO     = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] S_MID    = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] S_HI     = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] S_LAST   = CNT_W'(OVERSAMPLE - 1);

  rx_state_e        state, state_nxt;
  logic             rx_meta, rx_sync, rx_prev;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] samp_cnt;
  logic             tick;
  logic             samp_a, samp_b;
  logic             vote_bit, vote_stb;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             fall_edge, phase_rst, enter_break, cnt_clr;
  logic             do_shift, do_load, do_ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall_edge   = rx_prev & ~rx_sync;
  assign phase_rst   = (state == IDLE) && fall_edge;
  assign tick        = (div_cnt == DIV_LAST);
  assign enter_break = (state == STOP) && vote_stb && !vote_bit;
  // The break-recovery run of high ticks restarts on entry and on any low sample.
  assign cnt_clr     = phase_rst || enter_break || ((state == BREAK) && !rx_sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (phase_rst || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt <= '0;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
      vote_bit <= 1'b1;
      vote_stb <= 1'b0;
    end else begin
      vote_stb <= 1'b0;
      if (cnt_clr) begin
        samp_cnt <= '0;
      end else if (tick) begin
        samp_cnt <= (samp_cnt == S_LAST) ? '0 : samp_cnt + 1'b1;
        if (samp_cnt == S_LO)  samp_a <= rx_sync;
        if (samp_cnt == S_MID) samp_b <= rx_sync;
        if (samp_cnt == S_HI && (state == START || state == DATA || state == STOP)) begin
          vote_bit <= (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
          vote_stb <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_shift  = 1'b0;
    do_load   = 1'b0;
    do_ferr   = 1'b0;
    case (state)
      IDLE:  if (fall_edge) state_nxt = START;
      START: if (vote_stb) state_nxt = vote_bit ? IDLE : DATA;
      DATA: begin
        if (vote_stb) begin
          do_shift = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (vote_stb) begin
          if (vote_bit) begin
            do_load   = 1'b1;
            state_nxt = IDLE;
          end else begin
            do_ferr   = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: if (tick && samp_cnt == S_LAST && rx_sync) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= do_load;
      frame_err  <= do_ferr;
      if (state == START)  bit_cnt <= '0;
      else if (do_shift)   bit_cnt <= bit_cnt + 1'b1;
      if (do_shift)        shreg   <= {vote_bit, shreg[7:1]};
      if (do_load)         rx_byte <= shreg;
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver top: decodes received bytes into per-channel wave,
// frequency and noise registers with single-channel or broadcast targeting.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int NUM_CH     = 2,
  parameter int FREQ_W     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  output logic [NUM_CH*FREQ_W-1:0] freq_select,
  output logic [NUM_CH*3-1:0]      wave_select,
  output logic [NUM_CH-1:0]        white_noise_en,
  output logic [3:0]               active_ch,
  output logic                     broadcast,
  output logic                     byte_valid,
  output logic [7:0]               rx_byte,
  output logic                     frame_err
);

  logic       wave_hit, noise_hit, noise_val, freq_hit, sel_hit, bcast_hit;
  logic [2:0] wave_code;

  uart_rx_core #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  always_comb begin
    wave_hit  = 1'b0;
    wave_code = WAVE_TRI;
    noise_hit = 1'b0;
    noise_val = 1'b0;
    freq_hit  = 1'b0;
    sel_hit   = 1'b0;
    bcast_hit = 1'b0;
    if (byte_valid) begin
      case (rx_byte)
        CMD_T:     begin wave_hit = 1'b1; wave_code = WAVE_TRI; end
        CMD_S:     begin wave_hit = 1'b1; wave_code = WAVE_SAW; end
        CMD_Q:     begin wave_hit = 1'b1; wave_code = WAVE_SQR; end
        CMD_W:     begin wave_hit = 1'b1; wave_code = WAVE_SIN; end
        CMD_N:     begin noise_hit = 1'b1; noise_val = 1'b1; end
        CMD_F:     begin noise_hit = 1'b1; noise_val = 1'b0; end
        CMD_BCAST: bcast_hit = 1'b1;
        default: begin
          // Channel selects beyond the populated channels are dropped outright.
          if (rx_byte[7:4] == CMD_CH_BASE[7:4])
            sel_hit = ({1'b0, rx_byte[3:0]} < 5'(NUM_CH));
          else if (!rx_byte[7])
            freq_hit = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_select    <= '0;
      wave_select    <= '0;
      white_noise_en <= '0;
      active_ch      <= '0;
      broadcast      <= 1'b0;
    end else begin
      if (sel_hit) begin
        active_ch <= rx_byte[3:0];
        broadcast <= 1'b0;
      end
      if (bcast_hit) broadcast <= 1'b1;
      for (int n = 0; n < NUM_CH; n++) begin
        if (broadcast || active_ch == 4'(n)) begin
          if (wave_hit)  wave_select[n*3 +: 3]           <= wave_code;
          if (noise_hit) white_noise_en[n]               <= noise_val;
          if (freq_hit)  freq_select[n*FREQ_W +: FREQ_W] <= rx_byte[FREQ_W-1:0];
        end
      end
    end
  end

endmodule
